fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 88 ++++++++
 rtl/fetch_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: word width, default boot address, PC step helper,
// and the classification of an incoming instruction-memory response.
package fetch_unit_pkg;

  // Native instruction word width used across the CPU blocks.
  localparam int WORD_WIDTH = 32;

  // Default first fetch address after reset.
  localparam logic [WORD_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Bytes per instruction word, i.e. the sequential PC increment.
  function automatic int pc_step(input int data_width);
    return data_width / 8;
  endfunction

  // What happens to the response (if any) seen in a given cycle.
  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,  // no response this cycle
    RSP_PUSH  = 2'd1,  // live response, written to the queue
    RSP_DROP  = 2'd2,  // stale response from before a redirect, discarded
    RSP_FLUSH = 2'd3   // redirect cycle: any response discarded, drop reloaded
  } rsp_action_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {instruction, pc4}, registered head,
// synchronous clear with priority over push/pop, occupancy count output.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against occupancy; clear suppresses both.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (clear) begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
    end else begin
      do_push_s = push && (count_r != FULL_COUNT);
      do_pop_s  = pop && (count_r != {CW{1'b0}});
    end
  end

  // Entry storage; contents are meaningless until counted as valid.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Read/write pointers; DEPTH is a power of two so they wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Occupancy; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential fetches under a credit
// scheme, tracks in-flight requests, discards responses that belong to the
// path abandoned by a redirect, and buffers live instructions for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = WORD_WIDTH,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_code,
  output logic [ADDR_WIDTH-1:0] out_pc4
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(pc_step(DATA_WIDTH));
  localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_r;
  logic [ADDR_WIDTH-1:0] rsp_pc_r;       // address of the next live response
  logic [CW-1:0]         outstanding_r;
  logic [CW-1:0]         drop_r;
  logic [CW-1:0]         outstanding_next_s;
  logic [CW-1:0]         fifo_count_s;
  logic [CW:0]           credit_sum_s;
  logic                  req_fire_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_empty_s;
  logic [EW-1:0]         push_entry_s;
  logic [EW-1:0]         head_entry_s;
  rsp_action_e           rsp_action_s;

  // Credit check: every in-flight request already owns a queue slot, so the
  // queue can never overflow. Only registered state (and rst) is involved.
  always_comb begin
    credit_sum_s = {1'b0, fifo_count_s} + {1'b0, outstanding_r};
  end

  assign imem_req_valid = !rst && (credit_sum_s < CREDIT_LIMIT);
  assign imem_req_addr  = fetch_pc_r;
  assign req_fire_s     = imem_req_valid && imem_req_ready;

  // Classify this cycle's response: redirect beats everything, then stale
  // responses are dropped while the drop counter is non-zero.
  always_comb begin
    rsp_action_s = RSP_NONE;
    if (redirect_valid) begin
      rsp_action_s = RSP_FLUSH;
    end else if (imem_rsp_valid) begin
      if (drop_r != {CW{1'b0}}) begin
        rsp_action_s = RSP_DROP;
      end else begin
        rsp_action_s = RSP_PUSH;
      end
    end else begin
      rsp_action_s = RSP_NONE;
    end
  end

  // Next in-flight count: +1 per request fired, -1 per response returned.
  always_comb begin
    outstanding_next_s = outstanding_r;
    case ({req_fire_s, imem_rsp_valid})
      2'b10:   outstanding_next_s = outstanding_r + CW'(1);
      2'b01:   outstanding_next_s = outstanding_r - CW'(1);
      default: outstanding_next_s = outstanding_r;
    endcase
  end

  // In-flight request counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_r <= {CW{1'b0}};
    end else begin
      outstanding_r <= outstanding_next_s;
    end
  end

  // Fetch PC: a redirect wins over sequential advance; a request fired in
  // the redirect cycle used the old PC and is accounted as stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_pc;
    end else if (req_fire_s) begin
      fetch_pc_r <= fetch_pc_r + STEP;
    end
  end

  // Drop counter: on redirect every request still in flight (including one
  // fired this cycle) becomes stale; each stale response decrements it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_r <= {CW{1'b0}};
    end else begin
      case (rsp_action_s)
        RSP_FLUSH: drop_r <= outstanding_next_s;
        RSP_DROP:  drop_r <= drop_r - CW'(1);
        default:   drop_r <= drop_r;
      endcase
    end
  end

  // Address of the next live response: after a redirect the first live
  // response is for the target; afterwards it advances per accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_pc_r <= RESET_PC;
    end else begin
      case (rsp_action_s)
        RSP_FLUSH: rsp_pc_r <= redirect_pc;
        RSP_PUSH:  rsp_pc_r <= rsp_pc_r + STEP;
        default:   rsp_pc_r <= rsp_pc_r;
      endcase
    end
  end

  assign push_s       = (rsp_action_s == RSP_PUSH);
  assign pop_s        = out_valid && out_ready;
  assign push_entry_s = {imem_rsp_data, rsp_pc_r + STEP};

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .clear     (redirect_valid),
    .head_data (head_entry_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign out_valid = !fifo_empty_s;
  assign out_code  = head_entry_s[EW-1:ADDR_WIDTH];
  assign out_pc4   = head_entry_s[ADDR_WIDTH-1:0];

endmodule
